// File: rtl/neander_pkg.sv
// Shared constants for the Neander control unit: opcodes, ALU selects,
// dual RI/AC register enables and the controller state encoding.
package neander_pkg;

   localparam int unsigned OP_W     = 4;
   localparam int unsigned ALU_W    = 3;
   localparam int unsigned REG_EN_W = 2;

   localparam logic [OP_W-1:0] OP_NOP = 4'h0;
   localparam logic [OP_W-1:0] OP_STA = 4'h1;
   localparam logic [OP_W-1:0] OP_LDA = 4'h2;
   localparam logic [OP_W-1:0] OP_ADD = 4'h3;
   localparam logic [OP_W-1:0] OP_OR  = 4'h4;
   localparam logic [OP_W-1:0] OP_AND = 4'h5;
   localparam logic [OP_W-1:0] OP_NOT = 4'h6;
   localparam logic [OP_W-1:0] OP_JMP = 4'h8;
   localparam logic [OP_W-1:0] OP_JN  = 4'h9;
   localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
   localparam logic [OP_W-1:0] OP_HLT = 4'hF;

   localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
   localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_OR   = 3'b010;
   localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
   localparam logic [ALU_W-1:0] ALU_NOT  = 3'b100;

   localparam logic [REG_EN_W-1:0] REG_HOLD = 2'b00;
   localparam logic [REG_EN_W-1:0] REG_RI   = 2'b01;
   localparam logic [REG_EN_W-1:0] REG_AC   = 2'b10;

   typedef enum logic [3:0] {
      FETCH0, FETCH1, FETCH2, DECODE,
      OPA0, OPA1, PTR, RD, ALU,
      JUMP, STW0, STW1, HALT
   } state_t;

   function automatic logic [ALU_W-1:0] alu_sel(input logic [OP_W-1:0] op);
      logic [ALU_W-1:0] sel;
      case (op)
         OP_ADD:  sel = ALU_ADD;
         OP_OR:   sel = ALU_OR;
         OP_AND:  sel = ALU_AND;
         OP_NOT:  sel = ALU_NOT;
         default: sel = ALU_PASS;
      endcase
      return sel;
   endfunction

   function automatic logic is_jump(input logic [OP_W-1:0] op);
      return (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
   endfunction

endpackage

// File: rtl/neander_ctrl.sv
// Neander control unit: fetch/decode/execute sequencer whose strobes are a
// pure decode of the current state (plus opcode/flags while in DECODE).
module neander_ctrl
   import neander_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     opcode,
   input  logic                flag_n,
   input  logic                flag_z,
   output logic [REG_EN_W-1:0] reg_en,
   output logic                ld_pc,
   output logic                inc_pc,
   output logic                ld_rem,
   output logic                sel_rem,
   output logic                ld_rdm,
   output logic                sel_rdm,
   output logic                mem_wr,
   output logic [ALU_W-1:0]    alu_op,
   output logic                ld_nz,
   output logic                halted
);

   if (DATA_WIDTH == 0) begin : g_bad_width
      $error("neander_ctrl: DATA_WIDTH must be non-zero");
   end

   state_t          r_state;
   state_t          w_next;
   logic [OP_W-1:0] r_op;

   // Opcode is captured in DECODE so later states never look at the RI bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FETCH0;
         r_op    <= OP_NOP;
      end else begin
         r_state <= w_next;
         if (r_state == DECODE) begin
            r_op <= opcode;
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      reg_en  = REG_HOLD;
      ld_pc   = 1'b0;
      inc_pc  = 1'b0;
      ld_rem  = 1'b0;
      sel_rem = 1'b0;
      ld_rdm  = 1'b0;
      sel_rdm = 1'b0;
      mem_wr  = 1'b0;
      alu_op  = ALU_PASS;
      ld_nz   = 1'b0;
      halted  = 1'b0;

      case (r_state)
         FETCH0: begin
            ld_rem = 1'b1;
            w_next = FETCH1;
         end
         FETCH1: begin
            ld_rdm = 1'b1;
            inc_pc = 1'b1;
            w_next = FETCH2;
         end
         FETCH2: begin
            reg_en = REG_RI;
            w_next = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: w_next = OPA0;
               OP_NOT: w_next = ALU;
               OP_HLT: w_next = HALT;
               OP_JN: begin
                  // Untaken branch skips its operand byte.
                  if (flag_n) begin
                     w_next = OPA0;
                  end else begin
                     inc_pc = 1'b1;
                     w_next = FETCH0;
                  end
               end
               OP_JZ: begin
                  if (flag_z) begin
                     w_next = OPA0;
                  end else begin
                     inc_pc = 1'b1;
                     w_next = FETCH0;
                  end
               end
               default: w_next = FETCH0;
            endcase
         end
         OPA0: begin
            ld_rem = 1'b1;
            w_next = OPA1;
         end
         OPA1: begin
            ld_rdm = 1'b1;
            if (is_jump(r_op)) begin
               w_next = JUMP;
            end else begin
               inc_pc = 1'b1;
               w_next = PTR;
            end
         end
         PTR: begin
            ld_rem  = 1'b1;
            sel_rem = 1'b1;
            w_next  = (r_op == OP_STA) ? STW0 : RD;
         end
         RD: begin
            ld_rdm = 1'b1;
            w_next = ALU;
         end
         ALU: begin
            reg_en = REG_AC;
            ld_nz  = 1'b1;
            alu_op = alu_sel(r_op);
            w_next = FETCH0;
         end
         JUMP: begin
            ld_pc  = 1'b1;
            w_next = FETCH0;
         end
         STW0: begin
            ld_rdm  = 1'b1;
            sel_rdm = 1'b1;
            w_next  = STW1;
         end
         STW1: begin
            mem_wr = 1'b1;
            w_next = FETCH0;
         end
         HALT: begin
            halted = 1'b1;
            w_next = HALT;
         end
         default: w_next = FETCH0;
      endcase
   end

endmodule

// File: tb/tb_neander_ctrl.sv
// Self-checking bench for neander_ctrl: per-cycle expected strobe vectors
// are queued per instruction and popped against the DUT each cycle.
`timescale 1ns/1ps
module tb_neander_ctrl;

   typedef struct packed {
      logic [1:0] reg_en;
      logic       ld_pc;
      logic       inc_pc;
      logic       ld_rem;
      logic       sel_rem;
      logic       ld_rdm;
      logic       sel_rdm;
      logic       mem_wr;
      logic [2:0] alu_op;
      logic       ld_nz;
      logic       halted;
   } out_t;

   typedef out_t [0:8] seq_t;

   typedef struct packed {
      logic [3:0] op;
      logic       fn;
      logic       fz;
      logic [3:0] len;
      seq_t       seq;
   } vec_t;

   localparam out_t Z     = '0;
   localparam out_t E_F0  = '{ld_rem:1'b1, default:'0};
   localparam out_t E_F1  = '{ld_rdm:1'b1, inc_pc:1'b1, default:'0};
   localparam out_t E_F2  = '{reg_en:2'b01, default:'0};
   localparam out_t E_DEC = '0;
   localparam out_t E_DSK = '{inc_pc:1'b1, default:'0};
   localparam out_t E_OA0 = '{ld_rem:1'b1, default:'0};
   localparam out_t E_OAM = '{ld_rdm:1'b1, inc_pc:1'b1, default:'0};
   localparam out_t E_OAJ = '{ld_rdm:1'b1, default:'0};
   localparam out_t E_PTR = '{ld_rem:1'b1, sel_rem:1'b1, default:'0};
   localparam out_t E_RD  = '{ld_rdm:1'b1, default:'0};
   localparam out_t E_JMP = '{ld_pc:1'b1, default:'0};
   localparam out_t E_SW0 = '{ld_rdm:1'b1, sel_rdm:1'b1, default:'0};
   localparam out_t E_SW1 = '{mem_wr:1'b1, default:'0};
   localparam out_t E_HLT = '{halted:1'b1, default:'0};

   logic       clk;
   logic       rst;
   logic [3:0] opcode;
   logic       flag_n;
   logic       flag_z;
   logic [1:0] reg_en;
   logic       ld_pc, inc_pc, ld_rem, sel_rem, ld_rdm, sel_rdm, mem_wr;
   logic [2:0] alu_op;
   logic       ld_nz, halted;

   int   n_checks;
   int   n_errors;
   out_t sb[$];
   vec_t vecs [19];

   neander_ctrl #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .flag_n(flag_n), .flag_z(flag_z),
      .reg_en(reg_en), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_rem(ld_rem),
      .sel_rem(sel_rem), .ld_rdm(ld_rdm), .sel_rdm(sel_rdm), .mem_wr(mem_wr),
      .alu_op(alu_op), .ld_nz(ld_nz), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic out_t e_alu(input logic [2:0] a);
      out_t t = '0;
      t.reg_en = 2'b10;
      t.ld_nz  = 1'b1;
      t.alu_op = a;
      return t;
   endfunction

   function automatic seq_t s_nop();  return {E_F0, E_F1, E_F2, E_DEC, Z, Z, Z, Z, Z}; endfunction
   function automatic seq_t s_skip(); return {E_F0, E_F1, E_F2, E_DSK, Z, Z, Z, Z, Z}; endfunction
   function automatic seq_t s_hlt();  return {E_F0, E_F1, E_F2, E_DEC, E_HLT, Z, Z, Z, Z}; endfunction
   function automatic seq_t s_not();  return {E_F0, E_F1, E_F2, E_DEC, e_alu(3'b100), Z, Z, Z, Z}; endfunction
   function automatic seq_t s_jmp();  return {E_F0, E_F1, E_F2, E_DEC, E_OA0, E_OAJ, E_JMP, Z, Z}; endfunction
   function automatic seq_t s_sta();  return {E_F0, E_F1, E_F2, E_DEC, E_OA0, E_OAM, E_PTR, E_SW0, E_SW1}; endfunction
   function automatic seq_t s_mem(input logic [2:0] a);
      return {E_F0, E_F1, E_F2, E_DEC, E_OA0, E_OAM, E_PTR, E_RD, e_alu(a)};
   endfunction

   // Pop the next expected vector and compare it with the live outputs.
   task automatic check_out(input string tag, input int cyc);
      out_t got, want;
      got = out_t'({reg_en, ld_pc, inc_pc, ld_rem, sel_rem, ld_rdm, sel_rdm,
                    mem_wr, alu_op, ld_nz, halted});
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h want=<empty scoreboard>", tag, cyc, got);
      end else begin
         want = sb.pop_front();
         if (got !== want) begin
            n_errors++;
            $display("FAIL %s op=%h cyc=%0d got=%h want=%h", tag, opcode, cyc, got, want);
         end
      end
      n_checks++;
      if ((mem_wr && reg_en != 2'b00) || reg_en == 2'b11) begin
         n_errors++;
         $display("FAIL %s_excl cyc=%0d got mem_wr=%b reg_en=%b want exclusive/no 11",
                  tag, cyc, mem_wr, reg_en);
      end
   endtask

   // Enter and leave at a negedge with the DUT in FETCH0.
   task automatic run_vec(input string tag, input vec_t v, input bit sw,
                          input logic [3:0] op2, input logic f2);
      opcode = v.op;
      flag_n = v.fn;
      flag_z = v.fz;
      for (int c = 0; c < int'(v.len); c++) sb.push_back(v.seq[c]);
      for (int c = 0; c < int'(v.len); c++) begin
         check_out(tag, c + 1);
         if (sw && c == 4) begin
            opcode = op2;
            flag_n = f2;
            flag_z = f2;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      clk = 1'b0; rst = 1'b1; opcode = 4'h0; flag_n = 1'b0; flag_z = 1'b0;
      n_checks = 0; n_errors = 0;

      vecs[0]  = '{op:4'h0, fn:1'b0, fz:1'b0, len:4'd4, seq:s_nop()};
      vecs[1]  = '{op:4'h1, fn:1'b0, fz:1'b0, len:4'd9, seq:s_sta()};
      vecs[2]  = '{op:4'h2, fn:1'b0, fz:1'b0, len:4'd9, seq:s_mem(3'b000)};
      vecs[3]  = '{op:4'h3, fn:1'b0, fz:1'b0, len:4'd9, seq:s_mem(3'b001)};
      vecs[4]  = '{op:4'h4, fn:1'b1, fz:1'b1, len:4'd9, seq:s_mem(3'b010)};
      vecs[5]  = '{op:4'h5, fn:1'b0, fz:1'b1, len:4'd9, seq:s_mem(3'b011)};
      vecs[6]  = '{op:4'h6, fn:1'b1, fz:1'b0, len:4'd5, seq:s_not()};
      vecs[7]  = '{op:4'h7, fn:1'b1, fz:1'b1, len:4'd4, seq:s_nop()};
      vecs[8]  = '{op:4'h8, fn:1'b0, fz:1'b0, len:4'd7, seq:s_jmp()};
      vecs[9]  = '{op:4'h9, fn:1'b0, fz:1'b0, len:4'd4, seq:s_skip()};
      vecs[10] = '{op:4'h9, fn:1'b1, fz:1'b0, len:4'd7, seq:s_jmp()};
      vecs[11] = '{op:4'hA, fn:1'b1, fz:1'b0, len:4'd4, seq:s_skip()};
      vecs[12] = '{op:4'hA, fn:1'b0, fz:1'b1, len:4'd7, seq:s_jmp()};
      vecs[13] = '{op:4'hB, fn:1'b0, fz:1'b0, len:4'd4, seq:s_nop()};
      vecs[14] = '{op:4'hC, fn:1'b1, fz:1'b0, len:4'd4, seq:s_nop()};
      vecs[15] = '{op:4'hD, fn:1'b0, fz:1'b1, len:4'd4, seq:s_nop()};
      vecs[16] = '{op:4'hE, fn:1'b1, fz:1'b1, len:4'd4, seq:s_nop()};
      vecs[17] = '{op:4'h9, fn:1'b0, fz:1'b1, len:4'd4, seq:s_skip()};
      vecs[18] = '{op:4'hA, fn:1'b1, fz:1'b1, len:4'd7, seq:s_jmp()};

      // Reset state while rst is still asserted.
      repeat (3) @(negedge clk);
      sb.push_back(E_F0);
      check_out("reset", 0);
      rst = 1'b0;

      // NOP loop repeats every four cycles.
      for (int i = 0; i < 3; i++) run_vec("nop_loop", vecs[0], 1'b0, 4'h0, 1'b0);

      for (int i = 0; i < 19; i++) run_vec("table", vecs[i], 1'b0, 4'h0, 1'b0);

      // Inputs changing after DECODE must not alter the instruction.
      run_vec("add_late_op", vecs[3], 1'b1, 4'h6, 1'b1);
      run_vec("jn_late_flag", vecs[10], 1'b1, 4'h0, 1'b0);
      run_vec("sta_late_op", vecs[1], 1'b1, 4'h2, 1'b0);

      // Reset during RD of an LDA: no AC load may follow.
      v = vecs[2];
      opcode = v.op;
      for (int c = 0; c < 8; c++) sb.push_back(v.seq[c]);
      for (int c = 0; c < 8; c++) begin
         check_out("lda_rst", c + 1);
         if (c == 7) rst = 1'b1;
         @(negedge clk);
      end
      rst = 1'b0;
      run_vec("after_rst", vecs[0], 1'b0, 4'h0, 1'b0);

      // HLT parks the controller until reset.
      v = '{op:4'hF, fn:1'b0, fz:1'b0, len:4'd5, seq:s_hlt()};
      run_vec("hlt", v, 1'b0, 4'h0, 1'b0);
      opcode = 4'h3; flag_n = 1'b1; flag_z = 1'b1;
      for (int c = 0; c < 22; c++) begin
         sb.push_back(E_HLT);
         check_out("halt_hold", c + 6);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_vec("halt_exit", vecs[0], 1'b0, 4'h0, 1'b0);
      run_vec("post_halt_add", vecs[3], 1'b0, 4'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/neander_ctrl.md
NEANDER_CTRL -- requirements
Module: neander_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, datapath word width; no port of this block depends on it.
REQ-002 Port clk, input, 1, single clock; all state changes on posedge clk.
REQ-003 Port rst, input, 1, reset, synchronous and active-high.
REQ-004 Port opcode, input, 4, upper nibble of RI; sampled only in DECODE.
REQ-005 Port flag_n and port flag_z, both input, 1 each, AC negative/zero flags; sampled only in DECODE.
REQ-006 Port reg_en, output, 2, drives the dual RI/AC register: 2'b01 loads RI, 2'b10 loads AC, 2'b00 holds; 2'b11 is never driven.
REQ-007 Port ld_pc, output, 1, PC <- RDM.
REQ-008 Port inc_pc, output, 1, PC <- PC+1 mod 256.
REQ-009 Port ld_rem, output, 1, REM load strobe.
REQ-010 Port sel_rem, output, 1, REM source select: 0 = PC, 1 = RDM.
REQ-011 Port ld_rdm, output, 1, RDM load strobe.
REQ-012 Port sel_rdm, output, 1, RDM source select: 0 = memory, 1 = AC.
REQ-013 Port mem_wr, output, 1, memory write strobe (mem[REM] <- RDM).
REQ-014 Port alu_op, output, 3, ALU operation select.
REQ-015 Port ld_nz, output, 1, N/Z flag update strobe.
REQ-016 Port halted, output, 1, high while in HALT.

Function
REQ-017 The FSM SHALL use states FETCH0, FETCH1, FETCH2, DECODE, OPA0, OPA1, PTR, RD, ALU, JUMP, STW0, STW1 and HALT.
REQ-018 All strobes SHALL be 0 in any state that does not name them; strobes SHALL be a decode of the current state, plus opcode/flags in DECODE only.
REQ-019 FETCH0 SHALL assert ld_rem with sel_rem=0; FETCH1 SHALL assert ld_rdm (sel_rdm=0) and inc_pc; FETCH2 SHALL drive reg_en=01; each SHALL advance to the next fetch state, and FETCH2 SHALL go to DECODE.
REQ-020 Opcodes: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 8 JMP, 9 JN, A JZ, F HLT; 7, B-E SHALL behave as NOP.
REQ-021 In DECODE, NOP SHALL go to FETCH0 (4 cycles total) and HLT SHALL go to HALT.
REQ-022 In DECODE, NOT SHALL go to ALU; ALU SHALL drive reg_en=10, ld_nz=1 and alu_op per opcode, then go to FETCH0 (5 cycles total).
REQ-023 In DECODE, JN with flag_n=0 or JZ with flag_z=0 SHALL assert inc_pc (skip operand) and go to FETCH0 (4 cycles).
REQ-024 Taken JMP/JN/JZ SHALL go DECODE->OPA0->OPA1->JUMP->FETCH0 (7 cycles); OPA0 SHALL assert ld_rem with sel_rem=0, OPA1 SHALL assert ld_rdm, and JUMP SHALL assert ld_pc only.
REQ-025 LDA/ADD/OR/AND SHALL go OPA0->OPA1->PTR->RD->ALU->FETCH0 (9 cycles); for these, OPA1 SHALL also assert inc_pc, PTR SHALL assert ld_rem with sel_rem=1, and RD SHALL assert ld_rdm with sel_rdm=0.
REQ-026 STA SHALL go OPA0->OPA1->PTR->STW0->STW1->FETCH0 (9 cycles); STW0 SHALL assert ld_rdm with sel_rdm=1, STW1 SHALL assert mem_wr, and STA SHALL never assert ld_nz.
REQ-027 alu_op encoding SHALL be: 000 pass (LDA), 001 ADD, 010 OR, 011 AND, 100 NOT.
REQ-028 HALT SHALL hold halted=1 and all strobes 0 indefinitely, with no exit except rst.
REQ-029 mem_wr and any reg_en bit SHALL never be asserted in the same cycle.

Reset
REQ-030 When rst=1 at a clock edge, state SHALL become FETCH0 on that edge, overriding any state including HALT or mid-instruction.
REQ-031 rst SHALL take priority over every transition; in FETCH0 all outputs SHALL be 0 except ld_rem=1, and halted SHALL be 0.

Structure
REQ-032 Package neander_pkg SHALL hold the opcode constants, the alu_op encodings and the state enumeration.
REQ-033 The block SHALL be a single module with no sub-modules; the state register and next-state/output decode SHALL reside in it.

Verification
REQ-034 Scenario 1: release rst, opcode=0 held -> FETCH0..DECODE repeats every 4 cycles, inc_pc pulses once per loop, reg_en=01 once per loop.
REQ-035 Scenario 2: opcode=3 (ADD) -> 9-cycle sequence; reg_en=10 with alu_op=001 and ld_nz=1 in cycle 9; sel_rem=1 in cycle 7.
REQ-036 Scenario 3: opcode=9, flag_n=0 -> inc_pc in DECODE and back to FETCH0; repeat with flag_n=1 -> ld_pc in cycle 7, no inc_pc in DECODE.
REQ-037 Scenario 4: opcode=1 (STA) -> sel_rdm=1 with ld_rdm in cycle 8, mem_wr only in cycle 9, reg_en=00 throughout.
REQ-038 Scenario 5: opcode=F -> halted=1 from cycle 5 onward for 20+ cycles with all strobes 0; assert rst -> FETCH0 next edge, halted=0.
REQ-039 Scenario 6: rst pulsed during RD of an LDA -> no reg_en=10 follows; FETCH0 is entered on the next edge.
